// File: rtl/cl_adder_pkg.sv
// Shared types and helpers for the pipelined carry-lookahead adder.
//   op_flags_t        : per-operation flags that travel down the pipeline
//   DEF_WIDTH/BLOCK   : default operand width and bits resolved per stage
//   stages()          : number of pipeline stages for a width/block pair
//   sat_max/sat_min() : signed saturation limits, returned in a MAX_WIDTH
//                       container; callers size-cast to their own width
package cl_adder_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_BLOCK = 8;
   localparam int MAX_WIDTH = 256;

   typedef struct packed {
      logic sub;
      logic sat;
   } op_flags_t;

   function automatic int stages(input int width, input int block);
      return width / block;
   endfunction

   function automatic logic [MAX_WIDTH-1:0] sat_max(input int width);
      logic [MAX_WIDTH-1:0] r;
      r = '0;
      for (int i = 0; i < MAX_WIDTH; i++) begin
         if (i < width - 1) r[i] = 1'b1;
      end
      return r;
   endfunction

   function automatic logic [MAX_WIDTH-1:0] sat_min(input int width);
      logic [MAX_WIDTH-1:0] r;
      r = '0;
      r[width-1] = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/cla_slice.sv
// Combinational BLOCK-bit carry-lookahead slice.
//   a, b   : slice operands (b already inverted for subtraction)
//   cin    : carry into bit 0 of the slice
//   sum    : slice sum
//   cout   : carry out of the top bit
//   c_msb  : carry into the top bit (used for signed overflow)
module cla_slice #(
   parameter int BLOCK = 8
) (
   input  logic [BLOCK-1:0] a,
   input  logic [BLOCK-1:0] b,
   input  logic             cin,
   output logic [BLOCK-1:0] sum,
   output logic             cout,
   output logic             c_msb
);

   logic [BLOCK-1:0] g;
   logic [BLOCK-1:0] p;
   logic [BLOCK:0]   c;

   assign g = a & b;
   assign p = a ^ b;

   // Carry into bit n as a flat sum of products:
   // g[n-1] | p[n-1]g[n-2] | ... | p[n-1..0]cin
   function automatic logic lookahead(input logic [BLOCK-1:0] ga,
                                      input logic [BLOCK-1:0] pa,
                                      input logic             ci,
                                      input int               n);
      logic term;
      logic prop;
      term = 1'b0;
      prop = 1'b1;
      for (int j = BLOCK - 1; j >= 0; j--) begin
         if (j < n) begin
            term = term | (prop & ga[j]);
            prop = prop & pa[j];
         end
      end
      return term | (prop & ci);
   endfunction

   always_comb begin
      c    = '0;
      c[0] = cin;
      for (int i = 1; i <= BLOCK; i++) begin
         c[i] = lookahead(g, p, cin, i);
      end
   end

   assign sum   = p ^ c[BLOCK-1:0];
   assign cout  = c[BLOCK];
   assign c_msb = c[BLOCK-1];

endmodule

// File: rtl/cl_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor, one BLOCK-bit slice per stage.
// Optional feature macro: CL_PIPE_ADDER_SAT_EN (signed saturation on in_sat).
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : operation handshake (in_ready = pipeline advance)
//   in_a, in_b          : operands
//   in_cin              : carry-in (borrow-in when subtracting)
//   in_sub              : 1 = A - B, 0 = A + B
//   in_sat              : saturation request (ignored without the macro)
//   out_valid/out_ready : result handshake
//   out_sum             : result
//   out_cout            : raw carry out of the MSB
//   out_ovf             : signed overflow
// WIDTH must be a multiple of BLOCK.
module cl_pipe_adder
   import cl_adder_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int BLOCK = DEF_BLOCK
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_sub,
   input  logic             in_sat,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf
);

   localparam int STAGES = stages(WIDTH, BLOCK);

`ifdef CL_PIPE_ADDER_SAT_EN
   localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(sat_max(WIDTH));
   localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(sat_min(WIDTH));
`endif

   // x holds the operand-A bits still to be processed above the sum bits
   // already resolved, so one word carries both the unprocessed operand and
   // the skewed result; after the last stage it is the complete sum.
   typedef struct packed {
      logic             v;
      op_flags_t        f;
      logic             c;
      logic             ovf;
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] x;
   } stage_t;

   stage_t st_q [STAGES];
   stage_t st_d [STAGES];
   stage_t src0;
   logic   advance;

   assign advance  = !st_q[STAGES-1].v || out_ready;
   assign in_ready = advance;

   always_comb begin
      src0       = '0;
      src0.v     = in_valid;
      src0.f.sub = in_sub;
      src0.f.sat = in_sat;
      src0.c     = in_cin ^ in_sub;
      src0.b     = in_b ^ {WIDTH{in_sub}};
      src0.x     = in_a;
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      stage_t           src;
      stage_t           nxt;
      logic [BLOCK-1:0] sl_sum;
      logic             sl_cout;
      logic             sl_cmsb;

      if (k == 0) begin : g_first
         assign src = src0;
      end else begin : g_next
         assign src = st_q[k-1];
      end

      cla_slice #(.BLOCK(BLOCK)) u_slice (
         .a     (src.x[k*BLOCK +: BLOCK]),
         .b     (src.b[k*BLOCK +: BLOCK]),
         .cin   (src.c),
         .sum   (sl_sum),
         .cout  (sl_cout),
         .c_msb (sl_cmsb)
      );

      // ovf is only meaningful once the slice holding the MSB has resolved;
      // earlier stages compute it too and the next stage overwrites it.
      always_comb begin
         nxt                     = src;
         nxt.x[k*BLOCK +: BLOCK] = sl_sum;
         nxt.c                   = sl_cout;
         nxt.ovf                 = sl_cmsb ^ sl_cout;
`ifdef CL_PIPE_ADDER_SAT_EN
         // src.x[WIDTH-1] is still operand A's sign bit in the last stage.
         if ((k == STAGES - 1) && src.f.sat && nxt.ovf) begin
            nxt.x = src.x[WIDTH-1] ? SAT_MIN : SAT_MAX;
         end
`endif
      end

      assign st_d[k] = nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < STAGES; k++) st_q[k] <= '0;
      end else if (advance) begin
         for (int k = 0; k < STAGES; k++) st_q[k] <= st_d[k];
      end
   end

   assign out_valid = st_q[STAGES-1].v;
   assign out_sum   = st_q[STAGES-1].x;
   assign out_cout  = st_q[STAGES-1].c;
   assign out_ovf   = st_q[STAGES-1].ovf;

endmodule
